// File: rtl/mem_store_buffer_pkg.sv
// Shared opcode encoding and request classification for the store-buffered
// memory front end.
package mem_store_buffer_pkg;

  localparam int unsigned OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] LS_LB  = 3'b000;
  localparam logic [OP_WIDTH-1:0] LS_LBU = 3'b001;
  localparam logic [OP_WIDTH-1:0] LS_LH  = 3'b010;
  localparam logic [OP_WIDTH-1:0] LS_LHU = 3'b011;
  localparam logic [OP_WIDTH-1:0] LS_LW  = 3'b100;
  localparam logic [OP_WIDTH-1:0] LS_SB  = 3'b101;
  localparam logic [OP_WIDTH-1:0] LS_SH  = 3'b110;
  localparam logic [OP_WIDTH-1:0] LS_SW  = 3'b111;

  function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
    return op[2] & (|op[1:0]);
  endfunction

  function automatic logic is_misaligned(input logic [OP_WIDTH-1:0] op,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (op)
      LS_LH, LS_LHU, LS_SH: mis = addr_lo[0];
      LS_LW, LS_SW:         mis = |addr_lo;
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_store_buffer_sb_fifo.sv
// In-order store buffer: DEPTH entries with head/tail pointers, occupancy count
// and a parallel word-address match against all valid entries.
module mem_store_buffer_sb_fifo
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_push_addr,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic [OP_WIDTH-1:0]   i_push_op,
  input  logic                  i_pop,
  input  logic [ADDR_WIDTH-3:0] i_cmp_word,
  output logic [ADDR_WIDTH-1:0] o_head_addr,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [OP_WIDTH-1:0]   o_head_op,
  output logic                  o_hit,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [OP_WIDTH-1:0]   r_op   [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [PtrW:0]         r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pop clears before push sets; they never target the same slot when legal.
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PtrW'(1);
      end
      if (i_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PtrW'(1);
      end
      r_count <= r_count + (PtrW+1)'(i_push) - (PtrW+1)'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
      r_op[r_tail]   <= i_push_op;
    end
  end

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][ADDR_WIDTH-1:2] == i_cmp_word)) o_hit = 1'b1;
    end
  end

  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_head_op   = r_op[r_head];
  assign o_full      = (r_count == FullCount);
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/mem_store_buffer.sv
// Memory front end: classifies requests, arbitrates the single RAM port between
// loads and store-buffer drain, and registers load data and misalign exceptions.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_exc_misalign,
  output logic [ADDR_WIDTH-1:0] o_exc_addr,
  output logic                  o_sb_empty,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [2:0]            o_ram_load_store,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  logic                  w_store, w_mis, w_hit, w_full, w_empty, w_ready;
  logic                  w_accept, w_load_issue, w_push, w_pop;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [OP_WIDTH-1:0]   w_head_op;

  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_exc;
  logic [ADDR_WIDTH-1:0] r_exc_addr;

  assign w_store = is_store(i_req_op);
  assign w_mis   = is_misaligned(i_req_op, i_req_addr[1:0]);

  // A full buffer stalls every request so the drain is guaranteed to progress.
  always_comb begin
    w_ready = 1'b0;
    if (!w_full) begin
      if (w_mis || w_store) w_ready = 1'b1;
      else                  w_ready = !w_hit;
    end
  end

  assign o_req_ready  = w_ready;
  assign w_accept     = i_req_valid & w_ready;
  assign w_load_issue = w_accept & ~w_mis & ~w_store;
  assign w_push       = w_accept & ~w_mis & w_store;
  assign w_pop        = ~w_load_issue & ~w_empty;

  mem_store_buffer_sb_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sb_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_addr (i_req_addr),
    .i_push_data (i_req_wdata),
    .i_push_op   (i_req_op),
    .i_pop       (w_pop),
    .i_cmp_word  (i_req_addr[ADDR_WIDTH-1:2]),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_op   (w_head_op),
    .o_hit       (w_hit),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    o_ram_addr       = '0;
    o_ram_din        = '0;
    o_ram_we         = 1'b0;
    o_ram_re         = 1'b0;
    o_ram_load_store = '0;
    if (w_load_issue) begin
      o_ram_re         = 1'b1;
      o_ram_addr       = i_req_addr;
      o_ram_load_store = i_req_op;
    end else if (w_pop) begin
      o_ram_we         = 1'b1;
      o_ram_addr       = w_head_addr;
      o_ram_din        = w_head_data;
      o_ram_load_store = w_head_op;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_exc        <= 1'b0;
      r_exc_addr   <= '0;
    end else begin
      r_resp_valid <= w_load_issue;
      if (w_load_issue) r_resp_rdata <= i_ram_dout;
      r_exc <= w_accept & w_mis;
      if (w_accept && w_mis) r_exc_addr <= i_req_addr;
    end
  end

  assign o_resp_valid   = r_resp_valid;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_exc_misalign = r_exc;
  assign o_exc_addr     = r_exc_addr;
  assign o_sb_empty     = w_empty;

endmodule
